sum_n_serial: RTL

//   Parametrised multi-cycle adder/subtractor; successor of the 4-bit combinational sum4.

---
 rtl/sum_n_serial_if.sv | 26 ++
 rtl/sum_n_serial.sv | 113 +++++++++++
 2 files changed

// File: rtl/sum_n_serial_if.sv
// Handshake and operand/result bundle for the serial adder/subtractor.
interface sum_n_serial_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             c_in;
    logic             sub;
    logic [WIDTH-1:0] S;
    logic             c_out;
    logic             overflow;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output start, A, B, c_in, sub,
        input  S, c_out, overflow, zero, busy, done
    );

    modport slave (
        input  start, A, B, c_in, sub,
        output S, c_out, overflow, zero, busy, done
    );
endinterface

// File: rtl/sum_n_serial.sv
// Multi-cycle WIDTH-bit adder/subtractor: SLICE bits per clock through a
// registered carry, start/busy/done handshake, carry/overflow/zero flags.
module sum_n_serial #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    sum_n_serial_if.slave bus
);
    localparam int unsigned NSL = WIDTH / SLICE;
    localparam int unsigned CW  = (NSL > 1) ? $clog2(NSL) : 1;

    if (WIDTH % SLICE != 0) begin : g_bad_slice
        $error("sum_n_serial: WIDTH must be a multiple of SLICE");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic             load;
    logic [WIDTH-1:0] a_w, b_w, r_w, r_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [SLICE-1:0] a_sl, b_sl, sum_sl;
    logic [SLICE:0]   slice_sum;
    logic             carry_next, carry_msb, last;

    // Current slice add; the carry into the MSB falls out of the top bit of the slice.
    always_comb begin
        a_sl       = a_w[cnt*SLICE +: SLICE];
        b_sl       = b_w[cnt*SLICE +: SLICE];
        slice_sum  = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry};
        sum_sl     = slice_sum[SLICE-1:0];
        carry_next = slice_sum[SLICE];
        carry_msb  = a_sl[SLICE-1] ^ b_sl[SLICE-1] ^ sum_sl[SLICE-1];
        r_next     = r_w;
        r_next[cnt*SLICE +: SLICE] = sum_sl;
        last       = (cnt == CW'(NSL - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state, operand accept and handshake outputs.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                bus.done = 1'b1;
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Working operands, partial result, carry and slice counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_w   <= '0;
            b_w   <= '0;
            r_w   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            a_w   <= bus.A;
            b_w   <= bus.B ^ {WIDTH{bus.sub}};
            r_w   <= '0;
            carry <= bus.c_in;
            cnt   <= '0;
        end else if (state == RUN) begin
            r_w   <= r_next;
            carry <= carry_next;
            cnt   <= cnt + CW'(1);
        end
    end

    // Result and flags update only on the last slice, using the in-flight slice directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.S        <= '0;
            bus.c_out    <= 1'b0;
            bus.overflow <= 1'b0;
            bus.zero     <= 1'b0;
        end else if (state == RUN && last) begin
            bus.S        <= r_next;
            bus.c_out    <= carry_next;
            bus.overflow <= carry_msb ^ carry_next;
            bus.zero     <= (r_next == '0);
        end
    end
endmodule
